piso_shifter: RTL
=================

# piso_shifter

Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready load port and drives it out one bit per enabled clock, with per-bit valid and last-bit marker. It is the sending end for the serial capture flops produced by techmap. It clears to all-zero under an asynchronous active-low reset, the complement of the set-to-one sequential cells it feeds, and serves as a stimulus source in the sequential techmap simulation suites.

## Interface
- WIDTH, 8, bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 goes out first; 0 = bit 0 goes out first.

- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- load_valid  input  1  load_data is offered.
- load_ready  output  1  block accepts a word this cycle.
- load_data  input  WIDTH  word to serialise.
- shift_en  input  1  downstream consumes the current bit this cycle.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid data bit.
- sout_last  output  1  sout is the final bit of the word.

## Operation
- FSM states: IDLE, SHIFT.
- Registers: shreg[WIDTH-1:0], cnt[$clog2(WIDTH)-1:0], state.
- IDLE: load_ready=1, sout_valid=0, sout_last=0, sout=0.
- Accept = load_valid && load_ready. On accept: shreg<=load_data, cnt<=0, state<=SHIFT.
- SHIFT: sout_valid=1; sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]; sout_last = (cnt==WIDTH-1).
- SHIFT and shift_en, not last: shreg shifts toward the output end (zero fill), cnt<=cnt+1.
- SHIFT and shift_en and last: word complete. load_ready=1 in this cycle. On accept, reload and stay in SHIFT. No accept: go to IDLE.
- SHIFT and !shift_en: shreg, cnt and state hold. load_ready=0.
- load_ready = (state==IDLE) || (state==SHIFT && sout_last && shift_en). This is combinational from state, cnt and shift_en. There is no path from load_valid to load_ready.
- load_valid while load_ready=0 is ignored. The source must hold load_valid/load_data until it is accepted.
- shift_en in IDLE has no effect.
- cnt never exceeds WIDTH-1. No wrap-around occurs inside a word.

## Timing
- Reset values, asserted asynchronously: state=IDLE, shreg=0, cnt=0. This gives sout=0, sout_valid=0, sout_last=0 and load_ready=1.
- Reset mid-word: the partial word is discarded immediately, without waiting for a clock. The first edge after rst_n rises behaves as IDLE.
- Latency: accept at edge N puts the first bit on sout after edge N and before edge N+1.
- A word occupies exactly WIDTH cycles with shift_en held high.
- Back-to-back words with continuous shift_en give zero idle cycles. The first bit of word k+1 follows the last bit of word k on the next cycle.
- All outputs derive from registers except load_ready, which also depends on shift_en.

## Structure
- Shared package piso_pkg holds state_t (IDLE, SHIFT) as a 1-bit enum.
- The cnt width comes from a package function clog2_min1(WIDTH), which returns at least 1.
- Single module with no sub-module. Counter and shifter are trivial and stay inline.

## Test plan
- Reset with rst_n=0 mid-SHIFT, no clock edge -> sout=0, sout_valid=0, load_ready=1 within the same timestep.
- WIDTH=8, MSB_FIRST=1, load 8'hA5, shift_en=1 -> sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles. sout_last is high only on the 8th. Then IDLE.
- MSB_FIRST=0, load 8'hA5 -> sout=1,0,1,0,0,1,0,1 (LSB first: bits 0..7). Repeat with 8'h01 -> 1,0,0,0,0,0,0,0.
- Stall: load 8'hF0, drop shift_en for 3 cycles after the 2nd bit -> sout holds 1 and sout_valid stays 1 during the stall. load_ready=0. The total word takes 11 cycles.
- Back-to-back: load_valid held high with 8'hFF then 8'h00, shift_en=1 -> 16 consecutive valid bits (eight 1s, then eight 0s). sout_valid never drops, and sout_last is high on cycles 8 and 16.
- load_valid asserted during mid-word cycles -> ignored. The word is accepted only on the last-bit cycle, and the in-flight word is unchanged.

Source files
------------

// File: rtl/piso_shifter_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Smallest bit count able to hold 0..n-1, but never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) begin
        r = i + 32'sd1;
      end else begin
        r = r;
      end
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/piso_shifter_if.sv
// Load handshake and serial output bundle of the PISO transmitter.
interface piso_shifter_if #(
  parameter int WIDTH = 8
) ();

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;

  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, sout, sout_valid, sout_last
  );

  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, sout, sout_valid, sout_last
  );

endinterface

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word in, one bit per
// enabled clock out, with per-bit valid and a last-bit marker.
module piso_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  piso_shifter_if.slave  bus
);

  localparam int             CW       = clog2_min1(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;

  logic             last_s;
  logic             ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] shreg_shifted_s;

  // Handshake and serial outputs; only load_ready looks at shift_en.
  always_comb begin
    last_s   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    ready_s  = (state_q == IDLE) || (last_s && bus.shift_en);
    accept_s = bus.load_valid && ready_s;
    if (MSB_FIRST) begin
      shreg_shifted_s = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_shifted_s = {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  assign bus.load_ready = ready_s;
  assign bus.sout_valid = (state_q == SHIFT);
  assign bus.sout_last  = last_s;
  assign bus.sout       = (state_q == SHIFT) ?
                          (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : 1'b0;

  // Word sequencer: load, shift on enable, reload or fall idle after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            shreg_q <= bus.load_data;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (bus.shift_en && last_s) begin
            cnt_q <= '0;
            if (accept_s) begin
              shreg_q <= bus.load_data;
              state_q <= SHIFT;
            end else begin
              shreg_q <= '0;
              state_q <= IDLE;
            end
          end else if (bus.shift_en) begin
            shreg_q <= shreg_shifted_s;
            cnt_q   <= cnt_q + CW'(1);
          end else begin
            state_q <= SHIFT;
          end
        end
        default: begin
          state_q <= IDLE;
          shreg_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
